// File: rtl/cache_arb_pkg.sv
// Shared types for the cacheline arbiter: FSM state encoding, requester
// identity and the grant-selection helper used by cache_line_arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } arb_req_t;

  // A lone requester always wins; only a genuine tie consults tie_winner.
  function automatic arb_req_t pick_winner(input logic i_req,
                                           input logic d_req,
                                           input arb_req_t tie_winner);
    arb_req_t win;
    if (i_req && !d_req) begin
      win = REQ_I;
    end else if (d_req && !i_req) begin
      win = REQ_D;
    end else begin
      win = tie_winner;
    end
    return win;
  endfunction

endpackage

// File: rtl/cache_line_arbiter.sv
// Shares the single cacheline adaptor between the I-cache and D-cache.
// One whole line transaction is granted at a time; address/data are steered
// to the adaptor and the response is returned only to the winner.
// Build option: define CACHE_ARB_RR_EN for round-robin tie breaking
// (D_PRIORITY is then ignored); otherwise ties follow D_PRIORITY.
module cache_line_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // adaptor side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state;
  arb_req_t   tie_winner;
  arb_req_t   winner;
  logic       i_req;
  logic       d_req;

  // A D-cache request is either a fill or a write-back; both compete as one.
  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
  // Whoever was granted last loses the next tie.
  arb_req_t last_grant;
  assign tie_winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
  assign tie_winner = D_PRIORITY ? REQ_D : REQ_I;
`endif

  assign winner = pick_winner(i_req, d_req, tie_winner);

  // Grant FSM; mem_read/mem_write are registered at grant so the adaptor keeps
  // seeing the command even if the owner misbehaves and drops its request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_grant <= REQ_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
`ifdef CACHE_ARB_RR_EN
            last_grant <= winner;
`endif
            if (winner == REQ_D) begin
              state     <= SERVE_D;
              // write-back wins when both D commands are raised together
              mem_read  <= d_read & ~d_write;
              mem_write <= d_write;
            end else begin
              state     <= SERVE_I;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= RELEASE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        RELEASE: begin
          // dead cycle so the winner can drop its request before re-arbitration
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Steer the owner's address/data to the adaptor and route the response back
  // to the owner only; everything is zero outside the owner's states.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      SERVE_I: begin
        mem_addr = i_addr;
        i_resp   = mem_resp;
        if (mem_resp) begin
          i_rdata = mem_rdata;
        end
      end
      SERVE_D: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
        if (mem_resp) begin
          d_rdata = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
